// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave framing path.
package i2c_pkg;

    localparam int BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        DATA          = 3'd1,
        ACK_WAIT_FALL = 3'd2,
        ACK_LOW       = 3'd3,
        ACK_HIGH      = 3'd4
    } timer_state_t;

endpackage

// File: rtl/scl_edge_detect.sv
// SCL edge detector: one-cycle rise/fall flags from a synchronized line.
// The previous-sample register resets high so releasing reset with the line
// high never looks like an edge.
module scl_edge_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic SCL_sync,
    output logic rise,
    output logic fall
);

    logic scl_prev_q;

    // Remember last cycle's line level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) scl_prev_q <= 1'b1;
        else        scl_prev_q <= SCL_sync;
    end

    assign rise = SCL_sync & ~scl_prev_q;
    assign fall = ~SCL_sync & scl_prev_q;

endmodule

// File: rtl/i2c_slave_timer.sv
// I2C slave bit/byte framing timer. Counts SCL periods between START/STOP
// and emits registered single-cycle strobes for data shifting and the ACK slot.
// Optional SCL-low timeout is built when I2C_SCL_TIMEOUT_EN is defined.
module i2c_slave_timer
    import i2c_pkg::*;
#(
    parameter int BYTE_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 SCL_sync,
    input  logic                 start,
    input  logic                 stop,
    output logic                 rx_shift,
    output logic                 tx_shift,
    output logic                 byte_received,
    output logic                 ack_prep,
    output logic                 ack_check,
    output logic                 ack_done,
    output logic [BIT_CNT_W-1:0] bit_count,
    output logic                 timeout
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_BITS);

    timer_state_t         state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic rise, fall;
    logic to_evt;
    logic rx_q, rx_d, tx_q, tx_d, br_q, br_d;
    logic ap_q, ap_d, ac_q, ac_d, ad_q, ad_d, to_q, to_d;

    scl_edge_detect u_edge (
        .clk      (clk),
        .n_rst    (n_rst),
        .SCL_sync (SCL_sync),
        .rise     (rise),
        .fall     (fall)
    );

`ifdef I2C_SCL_TIMEOUT_EN
    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] tocnt_q, tocnt_d;

    // Low-time counter: parked in IDLE, cleared by a rise, counts while SCL low.
    always_comb begin
        to_evt  = (state_q != IDLE) && !SCL_sync && (tocnt_q == TO_LAST);
        tocnt_d = tocnt_q;
        if (state_q == IDLE || rise || to_evt) tocnt_d = '0;
        else if (!SCL_sync)                    tocnt_d = tocnt_q + 1'b1;
    end

    // Low-time counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) tocnt_q <= '0;
        else        tocnt_q <= tocnt_d;
    end
`else
    // TIMEOUT_CYCLES has no effect in this build.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign to_evt = 1'b0;
`endif

    // State and bit counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: stop beats start beats timeout beats any SCL edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start) begin
            state_d = DATA;
            cnt_d   = '0;
        end else if (to_evt) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DATA: begin
                    if (rise) begin
                        if (cnt_q != LAST_BIT)         cnt_d   = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == LAST_BIT)  state_d = ACK_WAIT_FALL;
                    end
                end
                ACK_WAIT_FALL: if (fall) state_d = ACK_LOW;
                ACK_LOW:       if (rise) state_d = ACK_HIGH;
                ACK_HIGH: begin
                    if (fall) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobe decode; start/stop/timeout suppress all framing strobes.
    always_comb begin
        rx_d = 1'b0;
        tx_d = 1'b0;
        br_d = 1'b0;
        ap_d = 1'b0;
        ac_d = 1'b0;
        ad_d = 1'b0;
        to_d = to_evt && !stop && !start;
        if (!stop && !start && !to_evt) begin
            case (state_q)
                DATA: begin
                    rx_d = rise;
                    br_d = rise && (cnt_q + 1'b1 == LAST_BIT);
                    // The fall right after START (count 0) shifts nothing.
                    tx_d = fall && (cnt_q != '0) && (cnt_q < LAST_BIT);
                end
                ACK_WAIT_FALL: ap_d = fall;
                ACK_LOW:       ac_d = rise;
                ACK_HIGH:      ad_d = fall;
                default: ;
            endcase
        end
    end

    // Strobe registers: every strobe lags its cause by one clk.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_q <= 1'b0;
            tx_q <= 1'b0;
            br_q <= 1'b0;
            ap_q <= 1'b0;
            ac_q <= 1'b0;
            ad_q <= 1'b0;
            to_q <= 1'b0;
        end else begin
            rx_q <= rx_d;
            tx_q <= tx_d;
            br_q <= br_d;
            ap_q <= ap_d;
            ac_q <= ac_d;
            ad_q <= ad_d;
            to_q <= to_d;
        end
    end

    assign rx_shift      = rx_q;
    assign tx_shift      = tx_q;
    assign byte_received = br_q;
    assign ack_prep      = ap_q;
    assign ack_check     = ac_q;
    assign ack_done      = ad_q;
    assign timeout       = to_q;
    assign bit_count     = cnt_q;

endmodule

// File: tb/tb_i2c_slave_timer.sv
// Scoreboard bench for i2c_slave_timer: stimulus queues expected strobes with
// their due cycle; a monitor pops one entry whenever any strobe is high.
module tb_i2c_slave_timer;

    localparam logic [6:0] M_RX = 7'h01;
    localparam logic [6:0] M_TX = 7'h02;
    localparam logic [6:0] M_BR = 7'h04;
    localparam logic [6:0] M_AP = 7'h08;
    localparam logic [6:0] M_AC = 7'h10;
    localparam logic [6:0] M_AD = 7'h20;
    localparam logic [6:0] M_TO = 7'h40;

    typedef struct {
        int         cyc;
        logic [6:0] mask;
        int         cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       SCL_sync = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       rx_shift, tx_shift, byte_received, ack_prep, ack_check, ack_done, timeout;
    logic [3:0] bit_count;
    logic [6:0] mask;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   ad_seen = 0;
    exp_t q[$];

    i2c_slave_timer #(.BYTE_BITS(8), .TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .SCL_sync      (SCL_sync),
        .start         (start),
        .stop          (stop),
        .rx_shift      (rx_shift),
        .tx_shift      (tx_shift),
        .byte_received (byte_received),
        .ack_prep      (ack_prep),
        .ack_check     (ack_check),
        .ack_done      (ack_done),
        .bit_count     (bit_count),
        .timeout       (timeout)
    );

    assign mask = {timeout, ack_done, ack_check, ack_prep, byte_received, tx_shift, rx_shift};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (n_rst && mask != 7'h00) begin
            checks++;
            if (mask[5]) ad_seen++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d got mask=%b cnt=%0d, required none", cyc, mask, bit_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.mask != mask || e.cnt != int'(bit_count)) begin
                    errors++;
                    $display("FAIL strobe got cyc=%0d mask=%b cnt=%0d, required cyc=%0d mask=%b cnt=%0d",
                             cyc, mask, bit_count, e.cyc, e.mask, e.cnt);
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog cycle budget expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive SCL at this negedge; optionally expect a strobe on the next cycle.
    task automatic set_scl(input logic v, input bit push, input logic [6:0] m, input int c);
        exp_t e;
        SCL_sync = v;
        if (push) begin
            e.cyc = cyc + 1; e.mask = m; e.cnt = c;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // One 8-bit byte plus ACK slot, SCL period 10 clk, starting with SCL low.
    task automatic send_byte();
        for (int i = 1; i <= 8; i++) begin
            set_scl(1'b1, 1'b1, (i == 8) ? (M_RX | M_BR) : M_RX, i);
            hold(4);
            set_scl(1'b0, 1'b1, (i == 8) ? M_AP : M_TX, i);
            hold(4);
        end
        set_scl(1'b1, 1'b1, M_AC, 8);
        hold(4);
        set_scl(1'b0, 1'b1, M_AD, 0);
        hold(4);
    endtask

    initial begin
        exp_t e;
        // Reset with SCL high, then 20 quiet cycles.
        hold(3);
        check("reset_outputs", int'({mask, bit_count}), 0);
        n_rst = 1'b1;
        hold(20);
        check("idle_bit_count", int'(bit_count), 0);

        // Two back-to-back bytes after one START.
        pulse_start();
        set_scl(1'b0, 1'b0, 7'h00, 0);
        hold(4);
        send_byte();
        check("byte1_bit_count", int'(bit_count), 0);
        check("byte1_ack_done", ad_seen, 1);
        send_byte();
        check("byte2_ack_done", ad_seen, 2);

        // STOP after the 4th rise, then clocks with no START are ignored.
        pulse_stop();
        set_scl(1'b1, 1'b0, 7'h00, 0);
        hold(4);
        pulse_start();
        set_scl(1'b0, 1'b0, 7'h00, 0);
        hold(4);
        for (int i = 1; i <= 4; i++) begin
            set_scl(1'b1, 1'b1, M_RX, i);
            hold(4);
            if (i < 4) begin
                set_scl(1'b0, 1'b1, M_TX, i);
                hold(4);
            end
        end
        pulse_stop();
        hold(2);
        check("stop_bit_count", int'(bit_count), 0);
        for (int i = 0; i < 3; i++) begin
            set_scl(1'b0, 1'b0, 7'h00, 0);
            hold(4);
            set_scl(1'b1, 1'b0, 7'h00, 0);
            hold(4);
        end
        check("post_stop_bit_count", int'(bit_count), 0);

        // Repeated START after 5 bits, coincident with a rise.
        pulse_start();
        set_scl(1'b0, 1'b0, 7'h00, 0);
        hold(4);
        for (int i = 1; i <= 5; i++) begin
            set_scl(1'b1, 1'b1, M_RX, i);
            hold(4);
            set_scl(1'b0, 1'b1, M_TX, i);
            hold(4);
        end
        check("pre_rstart_bit_count", int'(bit_count), 5);
        SCL_sync = 1'b1;
        pulse_start();
        hold(3);
        check("rstart_bit_count", int'(bit_count), 0);
        set_scl(1'b0, 1'b0, 7'h00, 0);
        hold(4);
        send_byte();
        check("rstart_ack_done", ad_seen, 3);

        // Glitch: rise and fall on consecutive cycles both count.
        set_scl(1'b1, 1'b1, M_RX, 1);
        set_scl(1'b0, 1'b1, M_TX, 1);
        hold(4);
        pulse_stop();
        set_scl(1'b1, 1'b0, 7'h00, 0);
        hold(4);

        // SCL held low mid-byte.
        pulse_start();
        set_scl(1'b0, 1'b0, 7'h00, 0);
        hold(4);
        set_scl(1'b1, 1'b1, M_RX, 1);
        hold(4);
        SCL_sync = 1'b0;
        e.cyc = cyc + 1; e.mask = M_TX; e.cnt = 1;
        q.push_back(e);
`ifdef I2C_SCL_TIMEOUT_EN
        e.cyc = cyc + 16; e.mask = M_TO; e.cnt = 0;
        q.push_back(e);
`endif
        @(negedge clk);
        hold(20);
`ifdef I2C_SCL_TIMEOUT_EN
        check("timeout_bit_count", int'(bit_count), 0);
`else
        check("no_timeout_bit_count", int'(bit_count), 1);
`endif
        pulse_stop();
        set_scl(1'b1, 1'b0, 7'h00, 0);
        hold(4);

        // Reset mid-byte: outputs clear, later clocks ignored until START.
        pulse_start();
        set_scl(1'b0, 1'b0, 7'h00, 0);
        hold(4);
        set_scl(1'b1, 1'b1, M_RX, 1);
        hold(4);
        set_scl(1'b0, 1'b1, M_TX, 1);
        hold(2);
        set_scl(1'b1, 1'b1, M_RX, 2);
        hold(2);
        n_rst = 1'b0;
        hold(2);
        check("midreset_outputs", int'({mask, bit_count}), 0);
        n_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_scl(1'b0, 1'b0, 7'h00, 0);
            hold(4);
            set_scl(1'b1, 1'b0, 7'h00, 0);
            hold(4);
        end
        check("post_reset_bit_count", int'(bit_count), 0);

        hold(5);
        check("queue_drained", q.size(), 0);
        check("total_ack_done", ad_seen, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
